// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only, one-word-per-line instruction cache.
//
// Sits between the instruction fetcher and the memory controller. A fetch
// request (rn/addr) that hits returns Inst with a one-cycle Read_ready pulse
// on the accepting edge. A miss issues a word read to the memory controller
// (mc_req/mc_addr, held until mc_ready), fills the line and bypasses the
// returned word to Inst. clr discards the result of an in-flight miss while
// still letting the fill complete.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   rdy               global ready; when low every register and the array hold
//   addr, rn          fetcher word address and read request
//   clr               flush from the flow controller
//   Inst, Read_ready  returned instruction and its one-cycle valid pulse
//   mc_req, mc_addr   word read request to the memory controller
//   mc_data, mc_ready returned word and its one-cycle completion pulse
//
// State table:
//   IDLE      | no miss outstanding; lookups accepted
//   MISS      | waiting on memory; returned word is delivered to the fetcher
//   MISS_DROP | waiting on memory; returned word only fills the line

module icache_direct #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr,
  input  logic        rn,
  input  logic        clr,
  output logic [31:0] Inst,
  output logic        Read_ready,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic [31:0] mc_data,
  input  logic        mc_ready
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS      = 2'd1,
    MISS_DROP = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       inst_q;
  logic              read_ready_q;
  logic              mc_req_q;
  logic [31:0]       mc_addr_q;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  // Lookup fields come from the live request address.
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_W-1:0]      lookup_tag;
  logic                  lookup_hit;
  logic                  accept;

  // Fill fields come from the latched miss address, so addr may wander
  // while the miss is outstanding.
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  fill_en;

  logic unused_addr_bits;

  assign lookup_idx = addr[INDEX_BITS+1:2];
  assign lookup_tag = addr[ADDR_BITS-1:INDEX_BITS+2];
  assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

  // Read_ready_q blocks the still-high rn of the delivery cycle from being
  // taken as a fresh request.
  assign accept = rn && !clr && !read_ready_q;

  assign fill_idx = mc_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mc_addr_q[ADDR_BITS-1:INDEX_BITS+2];
  assign fill_en  = rdy && mc_ready && (state_q != IDLE);

  assign unused_addr_bits = ^addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      inst_q       <= 32'd0;
      read_ready_q <= 1'b0;
      mc_req_q     <= 1'b0;
      mc_addr_q    <= 32'd0;
      valid_q      <= '0;
    end else if (rdy) begin
      read_ready_q <= 1'b0;
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (lookup_hit) begin
              inst_q       <= data_q[lookup_idx];
              read_ready_q <= 1'b1;
            end else begin
              state_q   <= MISS;
              mc_req_q  <= 1'b1;
              mc_addr_q <= {addr[31:2], 2'b00};
            end
          end
        end
        MISS: begin
          if (mc_ready) begin
            state_q  <= IDLE;
            mc_req_q <= 1'b0;
            // A flush on the completing edge still fills but does not deliver.
            if (!clr) begin
              inst_q       <= mc_data;
              read_ready_q <= 1'b1;
            end
          end else if (clr) begin
            // The memory read cannot be cancelled; keep mc_req until it lands.
            state_q <= MISS_DROP;
          end
        end
        MISS_DROP: begin
          if (mc_ready) begin
            state_q  <= IDLE;
            mc_req_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          mc_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc_data;
    end
  end

  assign Inst       = inst_q;
  assign Read_ready = read_ready_q;
  assign mc_req     = mc_req_q;
  assign mc_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct. Inputs change and outputs are sampled on
// the falling edge of clk; the DUT acts on the rising edge.

module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] addr;
  logic        rn;
  logic        clr;
  logic [31:0] Inst;
  logic        Read_ready;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic [31:0] mc_data;
  logic        mc_ready;

  int n_tests;
  int n_failed;

  icache_direct #(.INDEX_BITS(8), .ADDR_BITS(18)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .addr       (addr),
    .rn         (rn),
    .clr        (clr),
    .Inst       (Inst),
    .Read_ready (Read_ready),
    .mc_req     (mc_req),
    .mc_addr    (mc_addr),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Hit: Read_ready one cycle after rn; rn held over the delivery cycle must
  // not produce a second pulse or a memory request.
  task automatic do_hit(input string tag, input logic [31:0] a, input logic [31:0] exp_inst);
    addr = a;
    rn   = 1'b1;
    @(negedge clk);
    check({tag, " rr"},     {31'd0, Read_ready}, 32'd1);
    check({tag, " inst"},   Inst, exp_inst);
    check({tag, " no req"}, {31'd0, mc_req}, 32'd0);
    @(negedge clk);
    check({tag, " rr drop"}, {31'd0, Read_ready}, 32'd0);
    check({tag, " no req2"}, {31'd0, mc_req}, 32'd0);
    rn = 1'b0;
  endtask

  // Miss: mc_req/mc_addr next cycle, mc_ready after 'wait_cyc' cycles,
  // bypassed word delivered with a single Read_ready pulse.
  task automatic do_miss(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input int wait_cyc);
    addr = a;
    rn   = 1'b1;
    @(negedge clk);
    check({tag, " req"},   {31'd0, mc_req}, 32'd1);
    check({tag, " maddr"}, mc_addr, {a[31:2], 2'b00});
    check({tag, " rr0"},   {31'd0, Read_ready}, 32'd0);
    addr = 32'hFFFF_FFF0;  // latched address must be used for the fill
    for (int i = 0; i < wait_cyc - 1; i++) @(negedge clk);
    check({tag, " req held"}, {31'd0, mc_req}, 32'd1);
    mc_ready = 1'b1;
    mc_data  = d;
    @(negedge clk);
    mc_ready = 1'b0;
    mc_data  = 32'h0;
    check({tag, " rr"},     {31'd0, Read_ready}, 32'd1);
    check({tag, " inst"},   Inst, d);
    check({tag, " req off"}, {31'd0, mc_req}, 32'd0);
    @(negedge clk);
    check({tag, " rr drop"}, {31'd0, Read_ready}, 32'd0);
    check({tag, " no rereq"}, {31'd0, mc_req}, 32'd0);
    rn = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst      = 1'b0;
    rdy      = 1'b1;
    addr     = 32'h0;
    rn       = 1'b0;
    clr      = 1'b0;
    mc_data  = 32'h0;
    mc_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset rr",    {31'd0, Read_ready}, 32'd0);
    check("reset req",   {31'd0, mc_req}, 32'd0);
    check("reset inst",  Inst, 32'd0);
    check("reset maddr", mc_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss then hit.
    do_miss("cold", 32'h0000_0004, 32'h0050_0093, 3);
    do_hit("hit4", 32'h0000_0004, 32'h0050_0093);

    // Conflict on index 1.
    do_miss("conf404", 32'h0000_0404, 32'hDEAD_BEEF, 2);
    do_hit("hit404", 32'h0000_0404, 32'hDEAD_BEEF);
    do_miss("conf4", 32'h0000_0004, 32'h0050_0093, 1);

    // Flush one cycle before mc_ready: fill happens, nothing delivered.
    addr = 32'h0000_0010;
    rn   = 1'b1;
    @(negedge clk);
    check("flush req", {31'd0, mc_req}, 32'd1);
    @(negedge clk);
    rn  = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("flush req held", {31'd0, mc_req}, 32'd1);
    check("flush rr0",      {31'd0, Read_ready}, 32'd0);
    mc_ready = 1'b1;
    mc_data  = 32'h1234_5678;
    @(negedge clk);
    mc_ready = 1'b0;
    check("flush no rr", {31'd0, Read_ready}, 32'd0);
    check("flush req off", {31'd0, mc_req}, 32'd0);
    @(negedge clk);
    check("flush no rr2", {31'd0, Read_ready}, 32'd0);
    do_hit("flush hit", 32'h0000_0010, 32'h1234_5678);

    // clr together with mc_ready in MISS: fill, no delivery.
    addr = 32'h0000_0020;
    rn   = 1'b1;
    @(negedge clk);
    check("clrfill req", {31'd0, mc_req}, 32'd1);
    rn       = 1'b0;
    clr      = 1'b1;
    mc_ready = 1'b1;
    mc_data  = 32'hA5A5_0F0F;
    @(negedge clk);
    clr      = 1'b0;
    mc_ready = 1'b0;
    check("clrfill no rr",   {31'd0, Read_ready}, 32'd0);
    check("clrfill req off", {31'd0, mc_req}, 32'd0);
    do_hit("clrfill hit", 32'h0000_0020, 32'hA5A5_0F0F);

    // Pause during MISS: mc_ready while rdy=0 is ignored.
    addr = 32'h0000_0030;
    rn   = 1'b1;
    @(negedge clk);
    check("pause req", {31'd0, mc_req}, 32'd1);
    rdy      = 1'b0;
    mc_ready = 1'b1;
    mc_data  = 32'h0000_0BAD;
    @(negedge clk);
    mc_ready = 1'b0;
    check("pause rr0",   {31'd0, Read_ready}, 32'd0);
    check("pause req1",  {31'd0, mc_req}, 32'd1);
    repeat (2) @(negedge clk);
    check("pause req3",  {31'd0, mc_req}, 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("resume req",  {31'd0, mc_req}, 32'd1);
    check("resume rr0",  {31'd0, Read_ready}, 32'd0);
    mc_ready = 1'b1;
    mc_data  = 32'h0C0F_FEE0;
    @(negedge clk);
    mc_ready = 1'b0;
    check("resume rr",   {31'd0, Read_ready}, 32'd1);
    check("resume inst", Inst, 32'h0C0F_FEE0);
    @(negedge clk);
    rn = 1'b0;
    check("resume rr drop", {31'd0, Read_ready}, 32'd0);

    // Reset mid-miss: outputs clear immediately, cached lines are lost.
    addr = 32'h0000_0040;
    rn   = 1'b1;
    @(negedge clk);
    check("rstmiss req", {31'd0, mc_req}, 32'd1);
    rn = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rstmiss req0", {31'd0, mc_req}, 32'd0);
    check("rstmiss rr0",  {31'd0, Read_ready}, 32'd0);
    check("rstmiss inst", Inst, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_miss("post rst", 32'h0000_0004, 32'h0050_0093, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
